uio_bus_arbiter: RTL and testbench
==================================

Name: uio_bus_arbiter

Overview:
- Shares the 8 bidirectional uio pins between two on-chip requesters (A, B) ahead of the iCE40 SB_IO tristate cells.
- Grants the pins round-robin and registers the winner's uio_out/uio_oe.
- Enforces a turnaround gap (all oe low) between owners so two drivers never overlap on the pad.
- Limits how long one owner can keep the pins while the other waits.

Parameters:
- TURN_CYCLES, 2, idle cycles with uio_oe=0 between ownerships; legal range 1..15.
- MAX_HOLD, 16, cycles an owner may keep the bus while the other requests; 0 = unlimited; legal range 0..255.

Ports:
- clk  input  1  design clock (global buffer net)
- rst_n  input  1  asynchronous active-low reset
- req_a  input  1  requester A wants the pins; held high for the whole transfer
- req_b  input  1  requester B wants the pins
- a_out  input  8  A's pin output data; valid while req_a=1
- a_oe  input  8  A's per-pin output enable; valid while req_a=1
- b_out  input  8  B's pin output data
- b_oe  input  8  B's per-pin output enable
- gnt_a  output  1  A owns the pins (registered)
- gnt_b  output  1  B owns the pins (registered)
- uio_out  output  8  to SB_IO D_OUT_0 (registered)
- uio_oe  output  8  to SB_IO OUTPUT_ENABLE (registered)
- busy  output  1  high in GRANT or TURN

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt_a=gnt_b=0; uio_out=0; uio_oe=0; busy=0.
  - hold_cnt=0; turn_cnt=0; last=B, so A wins the first tie.
- Reset asserted mid-GRANT or mid-TURN: all outputs drop to reset values immediately, without waiting for the clock edge.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Any request: arbitrate, then go to GRANT on the next edge with the winner's gnt=1.
    - Latency from req rising to gnt: 1 cycle.
  - Arbitration: only one requester → it wins. Both → the one not equal to last wins. On grant, last := winner.
  - GRANT:
    - Every edge in GRANT: uio_out <= owner_out and uio_oe <= owner_oe.
    - The first driven pin value appears at the same edge that gnt rises.
    - hold_cnt increments each cycle and saturates at 255.
    - Release when the owner's req=0, or when MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and the other requester's req=1.
    - Release edge: gnt=0, uio_oe=0, uio_out=0, turn_cnt=TURN_CYCLES-1, go to TURN.
  - TURN:
    - gnt=0, uio_oe=0, uio_out=0; turn_cnt decrements each cycle.
    - When turn_cnt==0, arbitrate on that cycle's requests: a winner → GRANT next edge; none → IDLE.
    - Minimum uio_oe-low gap between two ownerships is exactly TURN_CYCLES cycles.
- Invariants:
  - gnt_a & gnt_b is never 1.
  - uio_oe != 0 only while a gnt is high.
  - Owner data is never gated by its own oe: uio_out follows owner_out even on pins where oe=0.
- Boundaries:
  - Owner drops req on its first grant cycle: release on the next edge; the gap still applies.
  - Both req rise in the same cycle from reset: A is granted.
  - MAX_HOLD expires with no other requester: the owner keeps the bus and hold_cnt keeps saturating.
  - A requester's req falls during TURN: it is not granted.
  - hold_cnt resets to 0 on every new grant.

Optional Feature:
- Macro: UIO_ARB_TURN_SKIP_EN.
- Defined:
  - Condition: at the TURN-exit arbitration, the winner equals the previous owner.
  - Action: TURN is skipped. Re-grant comes directly from the release edge, so gnt is low for exactly 1 cycle and uio_oe is low for 1 cycle.
  - Switching to the other requester still takes the full TURN_CYCLES gap.
- Not defined: every ownership change, including same-requester re-grant, waits TURN_CYCLES.

Test Plan:
- Reset, then req_a=1 with a_out=8'hA5, a_oe=8'h0F:
  - next edge gives gnt_a=1, uio_out=A5, uio_oe=0F, busy=1.
  - Drop req_a: next edge gives gnt_a=0 and uio_oe=00; IDLE after 2 cycles (TURN_CYCLES=2).
- req_a and req_b rise together from reset → gnt_a first. A releases → uio_oe=00 for exactly 2 cycles → gnt_b=1 with uio_out=b_out.
- req_a and req_b held high, MAX_HOLD=16:
  - gnt_a lasts 16 cycles, then a 2-cycle gap, then gnt_b lasts 16 cycles; alternation repeats.
  - gnt_a and gnt_b are never both high.
- Only req_a held for 300 cycles with MAX_HOLD=16 → gnt_a stays continuously high (no forced release).
- Assert rst_n=0 mid-GRANT (uio_oe=FF) → uio_oe=00 and gnt=0 before the next clock edge. After release, req_a,req_b=1 → A granted.
- UIO_ARB_TURN_SKIP_EN defined: A releases and re-requests with B idle → gnt_a low 1 cycle. Without the macro: low 2 cycles.

Source files
------------

// File: rtl/uio_bus_arbiter_if.sv
// Pin-sharing bundle between the two uio requesters and the arbiter.
// The master side drives the requests; the slave side is the arbiter.
interface uio_bus_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic [7:0] a_out;
  logic [7:0] a_oe;
  logic [7:0] b_out;
  logic [7:0] b_oe;
  logic       gnt_a;
  logic       gnt_b;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       busy;

  modport master (
    output req_a, req_b, a_out, a_oe, b_out, b_oe,
    input  gnt_a, gnt_b, uio_out, uio_oe, busy
  );

  modport slave (
    input  req_a, req_b, a_out, a_oe, b_out, b_oe,
    output gnt_a, gnt_b, uio_out, uio_oe, busy
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8 uio pads with a forced all-oe-low turnaround gap.
// Define UIO_ARB_TURN_SKIP_EN to skip the gap when the previous owner re-wins.
module uio_bus_arbiter #(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uio_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic       HOLD_EN   = (MAX_HOLD != 0);

  state_t     r_state, w_state;
  owner_t     r_owner, w_owner;
  owner_t     r_last,  w_last;
  logic [7:0] r_hold,  w_hold;
  logic [3:0] r_turn,  w_turn;
  logic       r_gnt_a, w_gnt_a;
  logic       r_gnt_b, w_gnt_b;
  logic [7:0] r_out,   w_out;
  logic [7:0] r_oe,    w_oe;

  logic       w_any;
  owner_t     w_win;
  logic       w_own_req;
  logic       w_oth_req;
  logic [7:0] w_own_out;
  logic [7:0] w_own_oe;
  logic [7:0] w_win_out;
  logic [7:0] w_win_oe;
  logic       w_release;
  logic       w_skip;
  logic       w_grant;

  always_comb begin
    w_any     = bus.req_a | bus.req_b;
    // On a tie the requester that did not win last time takes the pads.
    w_win     = (bus.req_b && (!bus.req_a || r_last == OWN_A)) ? OWN_B : OWN_A;
    w_own_req = (r_owner == OWN_A) ? bus.req_a : bus.req_b;
    w_oth_req = (r_owner == OWN_A) ? bus.req_b : bus.req_a;
    w_own_out = (r_owner == OWN_A) ? bus.a_out : bus.b_out;
    w_own_oe  = (r_owner == OWN_A) ? bus.a_oe  : bus.b_oe;
    w_win_out = (w_win == OWN_A)   ? bus.a_out : bus.b_out;
    w_win_oe  = (w_win == OWN_A)   ? bus.a_oe  : bus.b_oe;
    w_release = !w_own_req || (HOLD_EN && r_hold == HOLD_LAST && w_oth_req);
  end

`ifdef UIO_ARB_TURN_SKIP_EN
  assign w_skip = w_any && (w_win == r_last);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_last  = r_last;
    w_hold  = r_hold;
    w_turn  = r_turn;
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    w_out   = '0;
    w_oe    = '0;
    w_grant = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any) w_grant = 1'b1;
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state = ST_TURN;
          w_turn  = TURN_LAST;
        end else begin
          w_gnt_a = (r_owner == OWN_A);
          w_gnt_b = (r_owner == OWN_B);
          w_out   = w_own_out;
          w_oe    = w_own_oe;
          w_hold  = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
        end
      end
      ST_TURN: begin
        if (w_skip || r_turn == 4'd0) begin
          if (w_any) w_grant = 1'b1;
          else       w_state = ST_IDLE;
        end else begin
          w_turn = r_turn - 4'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    // A fresh grant drives the winner's pins on the same edge gnt rises.
    if (w_grant) begin
      w_state = ST_GRANT;
      w_owner = w_win;
      w_last  = w_win;
      w_hold  = '0;
      w_gnt_a = (w_win == OWN_A);
      w_gnt_b = (w_win == OWN_B);
      w_out   = w_win_out;
      w_oe    = w_win_oe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_A;
      r_last  <= OWN_B;
      r_hold  <= '0;
      r_turn  <= '0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_out   <= '0;
      r_oe    <= '0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_last  <= w_last;
      r_hold  <= w_hold;
      r_turn  <= w_turn;
      r_gnt_a <= w_gnt_a;
      r_gnt_b <= w_gnt_b;
      r_out   <= w_out;
      r_oe    <= w_oe;
    end
  end

  assign bus.gnt_a   = r_gnt_a;
  assign bus.gnt_b   = r_gnt_b;
  assign bus.uio_out = r_out;
  assign bus.uio_oe  = r_oe;
  assign bus.busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: expected outputs are queued per cycle
// by the driver and compared by an independent monitor after each edge.
module tb_uio_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uio_bus_arbiter_if bus_if ();

  uio_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    string       name;
    logic [18:0] val;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [18:0] pack(logic ga, logic gb, logic [7:0] o, logic [7:0] oe, logic bz);
    return {ga, gb, o, oe, bz};
  endfunction

  function automatic logic [18:0] dut_val();
    return {bus_if.gnt_a, bus_if.gnt_b, bus_if.uio_out, bus_if.uio_oe, bus_if.busy};
  endfunction

  task automatic check(input string n, input logic [18:0] act, input logic [18:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {gnt_a,gnt_b,out,oe,busy}=%b_%b_%h_%h_%b, expected %b_%b_%h_%h_%b",
               n, act[18], act[17], act[16:9], act[8:1], act[0],
               exp[18], exp[17], exp[16:9], exp[8:1], exp[0]);
    end
  endtask

  // One cycle of stimulus plus the output expected after the following edge.
  task automatic cyc(input logic ra, input logic rb, input string n,
                     input logic ga, input logic gb, input logic [7:0] o,
                     input logic [7:0] oe, input logic bz);
    exp_t e;
    @(negedge clk);
    bus_if.req_a = ra;
    bus_if.req_b = rb;
    e.name = n;
    e.val  = pack(ga, gb, o, oe, bz);
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.req_a = 1'b0;
    bus_if.req_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check(e.name, dut_val(), e.val);
      end
    end
  end

  initial begin : driver
    bus_if.req_a = 1'b0;
    bus_if.req_b = 1'b0;
    bus_if.a_out = 8'hA5;
    bus_if.a_oe  = 8'h0F;
    bus_if.b_out = 8'h3C;
    bus_if.b_oe  = 8'hF0;
    #2;
    check("reset_state", dut_val(), pack(0, 0, 8'h00, 8'h00, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, drops req on its first grant cycle.
    cyc(1, 0, "a_grant",   1, 0, 8'hA5, 8'h0F, 1);
    cyc(0, 0, "a_release", 0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "a_turn",    0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "a_idle",    0, 0, 8'h00, 8'h00, 0);

    // Simultaneous requests from reset: A first, then B after the gap.
    do_reset();
    cyc(1, 1, "tie_a",     1, 0, 8'hA5, 8'h0F, 1);
    cyc(0, 1, "tie_rel",   0, 0, 8'h00, 8'h00, 1);
    cyc(0, 1, "tie_gap",   0, 0, 8'h00, 8'h00, 1);
    cyc(0, 1, "tie_b",     0, 1, 8'h3C, 8'hF0, 1);
    cyc(0, 0, "b_release", 0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "b_turn",    0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "b_idle",    0, 0, 8'h00, 8'h00, 0);

    // Both held: 16-cycle tenures alternating with 2-cycle gaps.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 16; i++) cyc(1, 1, "hold_a", 1, 0, 8'hA5, 8'h0F, 1);
      for (int i = 0; i < 2; i++)  cyc(1, 1, "gap_ab", 0, 0, 8'h00, 8'h00, 1);
      for (int i = 0; i < 16; i++) cyc(1, 1, "hold_b", 0, 1, 8'h3C, 8'hF0, 1);
      for (int i = 0; i < 2; i++)  cyc(1, 1, "gap_ba", 0, 0, 8'h00, 8'h00, 1);
    end
    cyc(0, 0, "hold_idle", 0, 0, 8'h00, 8'h00, 0);

    // Lone requester is never forced off, even past hold saturation.
    for (int i = 0; i < 300; i++) cyc(1, 0, "solo_a", 1, 0, 8'hA5, 8'h0F, 1);
    cyc(0, 0, "solo_rel",  0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "solo_turn", 0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "solo_idle", 0, 0, 8'h00, 8'h00, 0);

    // Asynchronous reset while driving all pins.
    bus_if.a_oe = 8'hFF;
    cyc(1, 0, "pre_rst_a", 1, 0, 8'hA5, 8'hFF, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus_if.req_a = 1'b0;
    #1;
    check("async_rst", dut_val(), pack(0, 0, 8'h00, 8'h00, 0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 1, "post_rst_a", 1, 0, 8'hA5, 8'hFF, 1);
    cyc(0, 1, "post_rel",   0, 0, 8'h00, 8'h00, 1);
    cyc(0, 1, "post_gap",   0, 0, 8'h00, 8'h00, 1);
    cyc(0, 1, "post_b",     0, 1, 8'h3C, 8'hF0, 1);
    cyc(0, 0, "post_brel",  0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "post_bturn", 0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "post_idle",  0, 0, 8'h00, 8'h00, 0);
    bus_if.a_oe = 8'h0F;

    // Same requester re-requests right after releasing.
    cyc(1, 0, "re_a1",  1, 0, 8'hA5, 8'h0F, 1);
    cyc(0, 0, "re_rel", 0, 0, 8'h00, 8'h00, 1);
`ifdef UIO_ARB_TURN_SKIP_EN
    cyc(1, 0, "re_a2",  1, 0, 8'hA5, 8'h0F, 1);
`else
    cyc(1, 0, "re_gap", 0, 0, 8'h00, 8'h00, 1);
    cyc(1, 0, "re_a2",  1, 0, 8'hA5, 8'h0F, 1);
`endif
    cyc(0, 0, "re_rel2", 0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "re_turn", 0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "re_idle", 0, 0, 8'h00, 8'h00, 0);

    // B's request vanishes during the gap: nobody is granted.
    cyc(1, 0, "drop_a",    1, 0, 8'hA5, 8'h0F, 1);
    cyc(0, 1, "drop_rel",  0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "drop_turn", 0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, "drop_idle", 0, 0, 8'h00, 8'h00, 0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
